// File: rtl/div_hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_hilo_sequencer
// Purpose  : Multi-cycle unsigned restoring divider (DIVU) for the EX stage.
//            It also owns the HI/LO register pair and serves MFHI/MFLO reads.
//            The quotient goes to LO and the remainder to HI. While a divide
//            is in flight, any DIVU/MFHI/MFLO presented by EX is stalled until
//            the sequencer is back in IDLE.
//
// Parameters
//   WIDTH        operand width (default 32)
//   STEPS        quotient bits resolved per clock, 1 or 2; WIDTH % STEPS == 0
//
// Ports
//   div_clk      in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   op_valid     in   EX-stage instruction valid
//   funct        in   DIVU=6'b011011, MFHI=6'b010000, MFLO=6'b010010
//   abort        in   (DIV_ABORT_EN only) cancel a divide that is in RUN
//   dataA        in   dividend, sampled when DIVU is accepted
//   dataB        in   divisor, sampled when DIVU is accepted
//   stall        out  combinational; hold EX and upstream stages
//   busy         out  registered; high in RUN and DONE
//   done         out  registered; one-cycle pulse in DONE
//   div_by_zero  out  registered; set when the last DIVU had divisor 0
//   hilo_out     out  combinational; HI for MFHI, LO for MFLO, else 0
//   alu_out_sel  out  combinational; hilo_out replaces the ALU result
//
// Configuration
//   DIV_ABORT_EN  when defined, adds the abort input. abort in RUN returns to
//                 IDLE without touching HI, LO or div_by_zero and without a
//                 done pulse. rst has priority over abort.
//
// Revision : 1.0  initial release
// ============================================================================
module div_hilo_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [5:0]       funct,
`ifdef DIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hilo_out,
    output logic             alu_out_sel
);

    localparam int         c_CNT_W      = $clog2(WIDTH + 1);
    localparam logic [5:0] c_FUNCT_DIVU = 6'b011011;
    localparam logic [5:0] c_FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] c_FUNCT_MFLO = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_divisor;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_is_divu;
    logic                 w_is_mfhi;
    logic                 w_is_mflo;
    logic                 w_idle;
    logic                 w_accept;
    logic [WIDTH:0]       w_rem;
    logic [WIDTH-1:0]     w_quo;
    logic [c_CNT_W-1:0]   w_count_next;
    logic                 w_run_last;

    // ------------------------------------------------------------------
    // Instruction decode and pipeline handshake
    // ------------------------------------------------------------------
    assign w_is_divu = (funct == c_FUNCT_DIVU);
    assign w_is_mfhi = (funct == c_FUNCT_MFHI);
    assign w_is_mflo = (funct == c_FUNCT_MFLO);
    assign w_idle    = (r_state == S_IDLE);
    assign w_accept  = w_idle & op_valid & w_is_divu;

    // Only instructions that touch the divider or HI/LO wait for it; any
    // other instruction flows past a running divide untouched.
    assign stall       = op_valid & (w_is_divu | w_is_mfhi | w_is_mflo) & ~w_idle;
    assign alu_out_sel = op_valid & (w_is_mfhi | w_is_mflo) & w_idle;
    assign hilo_out    = alu_out_sel ? (w_is_mfhi ? r_hi : r_lo) : '0;

    // ------------------------------------------------------------------
    // Restoring divide datapath: STEPS iterations per clock.
    // {rem,quo} shifts left as one register; rem carries an extra bit so
    // that the shifted partial remainder (< 2*divisor) never overflows
    // before the compare.
    // ------------------------------------------------------------------
    always_comb begin
        w_rem = r_rem;
        w_quo = r_quo;
        for (int i = 0; i < STEPS; i++) begin
            w_rem = (w_rem << 1) | {{WIDTH{1'b0}}, w_quo[WIDTH-1]};
            w_quo = w_quo << 1;
            if (w_rem >= {1'b0, r_divisor}) begin
                w_rem    = w_rem - {1'b0, r_divisor};
                w_quo[0] = 1'b1;
            end
        end
    end

    assign w_count_next = r_count + c_CNT_W'(STEPS);
    assign w_run_last   = (w_count_next == c_CNT_W'(WIDTH));

    // ------------------------------------------------------------------
    // Sequencer: IDLE -> RUN -> DONE -> IDLE (divide-by-zero skips RUN).
    // HI/LO are written only on entry to DONE, so MFHI/MFLO never observe
    // a partial result.
    // ------------------------------------------------------------------
    always_ff @(posedge div_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hi        <= '0;
            r_lo        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        r_divisor <= dataB;
                        r_quo     <= dataA;
                        r_rem     <= '0;
                        r_count   <= '0;
                        busy      <= 1'b1;
                        if (dataB == '0) begin
                            // Defined result for x/0: HI keeps the dividend,
                            // LO saturates to all ones.
                            r_state     <= S_DONE;
                            r_hi        <= dataA;
                            r_lo        <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            div_by_zero <= 1'b0;
                        end
                    end
                end

                S_RUN: begin
`ifdef DIV_ABORT_EN
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
`else
                    begin
`endif
                        r_rem   <= w_rem;
                        r_quo   <= w_quo;
                        r_count <= w_count_next;
                        if (w_run_last) begin
                            r_state <= S_DONE;
                            r_hi    <= w_rem[WIDTH-1:0];
                            r_lo    <= w_quo;
                            done    <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // No accept here: a DIVU waiting on stall is taken in
                    // the following IDLE cycle.
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_hilo_sequencer
// Purpose  : Self-checking bench for div_hilo_sequencer. A STEPS=1 instance
//            takes directed and random divides; a STEPS=2 instance checks the
//            shorter latency. Expected HI/LO come from the / and % operators,
//            expected latency from WIDTH/STEPS+1 (1 for a zero divisor).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div_hilo_sequencer;

    localparam int         W      = 32;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    logic         div_clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [5:0]   funct;
    logic [W-1:0] dataA, dataB;
    logic         stall, busy, done, div_by_zero, alu_out_sel;
    logic [W-1:0] hilo_out;

    logic         s2_op_valid;
    logic [5:0]   s2_funct;
    logic [W-1:0] s2_dataA, s2_dataB;
    logic         s2_stall, s2_busy, s2_done, s2_dbz, s2_sel;
    logic [W-1:0] s2_hilo;
`ifdef DIV_ABORT_EN
    logic         abort;
    logic         s2_abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference architectural state of the STEPS=1 instance
    logic [W-1:0] m_hi, m_lo;
    logic         m_dbz;

    always #5 div_clk = ~div_clk;

    div_hilo_sequencer #(.WIDTH(W), .STEPS(1)) dut (
        .div_clk     (div_clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .funct       (funct),
`ifdef DIV_ABORT_EN
        .abort       (abort),
`endif
        .dataA       (dataA),
        .dataB       (dataB),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hilo_out    (hilo_out),
        .alu_out_sel (alu_out_sel)
    );

    div_hilo_sequencer #(.WIDTH(W), .STEPS(2)) dut2 (
        .div_clk     (div_clk),
        .rst         (rst),
        .op_valid    (s2_op_valid),
        .funct       (s2_funct),
`ifdef DIV_ABORT_EN
        .abort       (s2_abort),
`endif
        .dataA       (s2_dataA),
        .dataB       (s2_dataB),
        .stall       (s2_stall),
        .busy        (s2_busy),
        .done        (s2_done),
        .div_by_zero (s2_dbz),
        .hilo_out    (s2_hilo),
        .alu_out_sel (s2_sel)
    );

    // ------------------------------------------------------------------
    task automatic read_hilo(input logic [5:0] f, input logic [W-1:0] exp, input string nm);
        @(negedge div_clk);
        op_valid = 1'b1;
        funct    = f;
        #1;
        n_checks++;
        if (stall !== 1'b0 || alu_out_sel !== 1'b1 || hilo_out !== exp) begin
            n_errors++;
            $display("FAIL %s: stall=%0b sel=%0b hilo=%h, expected stall=0 sel=1 hilo=%h",
                     nm, stall, alu_out_sel, hilo_out, exp);
        end
        @(posedge div_clk); #1;
        op_valid = 1'b0;
        funct    = 6'd0;
    endtask

    task automatic accept_div(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        @(negedge div_clk);
        op_valid = 1'b1;
        funct    = F_DIVU;
        dataA    = a;
        dataB    = b;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_accept_stall: stall=%0b, expected 0", nm, stall);
        end
        @(posedge div_clk); #1;
        op_valid = 1'b0;
        funct    = 6'd0;
        dataA    = $urandom;   // operands must already be latched
        dataB    = $urandom;
    endtask

    function automatic logic [5:0] rand_other_funct();
        logic [5:0] f;
        f = 6'($urandom_range(0, 63));
        while (f == F_DIVU || f == F_MFHI || f == F_MFLO) f = 6'($urandom_range(0, 63));
        return f;
    endfunction

    // Waits for done after an accepted DIVU, then checks latency, flag and
    // both result registers against the arithmetic model.
    task automatic finish_div(input logic [W-1:0] a, input logic [W-1:0] b, input string nm,
                              input bit noise);
        int lat, exp_lat;
        bit bad_busy, bad_noise;
        if (b == '0) begin
            m_hi = a; m_lo = '1; m_dbz = 1'b1; exp_lat = 1;
        end else begin
            m_hi = a % b; m_lo = a / b; m_dbz = 1'b0; exp_lat = W + 1;
        end
        lat = 0; bad_busy = 0; bad_noise = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge div_clk);
            if (noise) begin
                op_valid = 1'b1;
                funct    = rand_other_funct();
            end
            #1;
            if (busy !== 1'b1) bad_busy = 1;
            if (noise && (stall !== 1'b0 || alu_out_sel !== 1'b0 || hilo_out !== '0)) bad_noise = 1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        op_valid = 1'b0;
        funct    = 6'd0;
        n_checks++;
        if (lat != exp_lat) begin
            n_errors++;
            $display("FAIL %s_latency: done at cycle %0d, expected %0d", nm, lat, exp_lat);
        end
        n_checks++;
        if (bad_busy) begin
            n_errors++;
            $display("FAIL %s_busy: busy dropped before done, expected 1 throughout", nm);
        end
        if (noise) begin
            n_checks++;
            if (bad_noise) begin
                n_errors++;
                $display("FAIL %s_other_funct: stall/sel/hilo nonzero, expected 0/0/0", nm);
            end
        end
        n_checks++;
        if (div_by_zero !== m_dbz) begin
            n_errors++;
            $display("FAIL %s_dbz: div_by_zero=%0b, expected %0b", nm, div_by_zero, m_dbz);
        end
        @(negedge div_clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_after_done: busy=%0b done=%0b, expected 0 0", nm, busy, done);
        end
        read_hilo(F_MFLO, m_lo, {nm, "_lo"});
        read_hilo(F_MFHI, m_hi, {nm, "_hi"});
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        accept_div(a, b, nm);
        finish_div(a, b, nm, 1'b0);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge div_clk);
        @(negedge div_clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || stall !== 1'b0 ||
            s2_busy !== 1'b0 || s2_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b dbz=%0b stall=%0b s2_busy=%0b s2_done=%0b, expected all 0",
                     busy, done, div_by_zero, stall, s2_busy, s2_done);
        end
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        read_hilo(F_MFHI, '0, "reset_hi");
        read_hilo(F_MFLO, '0, "reset_lo");
    endtask

    task automatic test_directed();
        run_div(32'd100, 32'd7, "d100_7");
        run_div(32'hFFFF_FFFF, 32'd1, "dmax_1");
        run_div(32'd3, 32'd10, "d3_10");
        run_div(32'd5, 32'd0, "d5_0");
        run_div(32'd9, 32'd3, "d9_3");
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, "dmax_max");
        run_div(32'h8000_0001, 32'h8000_0000, "dmsb");
    endtask

    task automatic test_stall_mf();
        bit bad = 0;
        @(negedge div_clk);
        op_valid = 1'b1; funct = F_DIVU; dataA = 32'd1000; dataB = 32'd33;
        @(posedge div_clk); #1;
        funct = F_MFLO; dataA = '0; dataB = '0;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge div_clk); #1;
            if (stall !== 1'b1 || alu_out_sel !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL mf_stall_busy: stall/sel wrong while busy, expected stall=1 sel=0");
        end
        @(negedge div_clk); #1;
        n_checks++;
        if (stall !== 1'b0 || alu_out_sel !== 1'b1 || hilo_out !== 32'd30) begin
            n_errors++;
            $display("FAIL mf_first_idle: stall=%0b sel=%0b hilo=%0d, expected 0 1 30",
                     stall, alu_out_sel, hilo_out);
        end
        @(posedge div_clk); #1;
        funct = F_MFHI;
        @(negedge div_clk); #1;
        n_checks++;
        if (stall !== 1'b0 || alu_out_sel !== 1'b1 || hilo_out !== 32'd10) begin
            n_errors++;
            $display("FAIL mf_hi_next: stall=%0b sel=%0b hilo=%0d, expected 0 1 10",
                     stall, alu_out_sel, hilo_out);
        end
        @(posedge div_clk); #1;
        op_valid = 1'b0; funct = 6'd0;
        m_hi = 32'd10; m_lo = 32'd30; m_dbz = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit bad = 0;
        logic [W-1:0] a2 = 32'd123456789;
        logic [W-1:0] b2 = 32'd1000;
        @(negedge div_clk);
        op_valid = 1'b1; funct = F_DIVU; dataA = 32'd1000000; dataB = 32'd7;
        @(posedge div_clk); #1;
        dataA = a2; dataB = b2;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge div_clk); #1;
            if (stall !== 1'b1) bad = 1;
            if (done !== ((c == W + 1) ? 1'b1 : 1'b0)) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL b2b_first: stall/done wrong during first divide, expected stall=1 and done only at cycle %0d", W + 1);
        end
        @(negedge div_clk); #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second_accept: stall=%0b, expected 0", stall);
        end
        @(posedge div_clk); #1;
        op_valid = 1'b0; funct = 6'd0;
        finish_div(a2, b2, "b2b_second", 1'b0);
    endtask

    task automatic test_other_funct();
        @(negedge div_clk);
        op_valid = 1'b1; funct = 6'b100001; dataA = 32'd50; dataB = 32'd5;
        #1;
        n_checks++;
        if (stall !== 1'b0 || alu_out_sel !== 1'b0 || hilo_out !== '0) begin
            n_errors++;
            $display("FAIL other_idle: stall=%0b sel=%0b hilo=%h, expected 0 0 0",
                     stall, alu_out_sel, hilo_out);
        end
        @(posedge div_clk); #1;
        op_valid = 1'b0; funct = F_DIVU;   // DIVU without valid must not start
        @(posedge div_clk); #1;
        funct = 6'd0;
        @(negedge div_clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL other_no_accept: busy=%0b, expected 0", busy);
        end
        accept_div(32'd777777, 32'd13, "other_run");
        finish_div(32'd777777, 32'd13, "other_run", 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 20));
                1:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_div(a, b, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid_run();
        run_div(32'd100, 32'd7, "pre_reset");
        accept_div(32'd123456, 32'd789, "mid_reset");
        repeat (10) @(negedge div_clk);
        @(negedge div_clk);
        rst = 1'b1;
        @(posedge div_clk); #1;
        rst = 1'b0;
        @(negedge div_clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_state: busy=%0b done=%0b dbz=%0b, expected 0 0 0",
                     busy, done, div_by_zero);
        end
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        read_hilo(F_MFHI, '0, "mid_reset_hi");
        read_hilo(F_MFLO, '0, "mid_reset_lo");
    endtask

`ifdef DIV_ABORT_EN
    task automatic test_abort();
        bit bad = 0;
        run_div(32'd7, 32'd100, "pre_abort");
        accept_div(32'd50, 32'd5, "abort");
        repeat (4) @(negedge div_clk);
        @(negedge div_clk);
        abort = 1'b1;
        @(posedge div_clk); #1;
        abort = 1'b0;
        @(negedge div_clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_idle: busy=%0b done=%0b, expected 0 0", busy, done);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge div_clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL abort_no_done: done/busy rose after abort, expected 0");
        end
        read_hilo(F_MFHI, 32'd7, "abort_hi");
        read_hilo(F_MFLO, 32'd0, "abort_lo");
    endtask
`endif

    task automatic run_div2(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        int lat = 0;
        int exp_lat = (b == '0) ? 1 : W / 2 + 1;
        logic [W-1:0] e_hi = (b == '0) ? a : a % b;
        logic [W-1:0] e_lo = (b == '0) ? '1 : a / b;
        @(negedge div_clk);
        s2_op_valid = 1'b1; s2_funct = F_DIVU; s2_dataA = a; s2_dataB = b;
        @(posedge div_clk); #1;
        s2_op_valid = 1'b0; s2_funct = 6'd0; s2_dataA = $urandom; s2_dataB = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge div_clk); #1;
            if (s2_done === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_errors++;
            $display("FAIL %s_latency: done at cycle %0d, expected %0d", nm, lat, exp_lat);
        end
        @(negedge div_clk);
        s2_op_valid = 1'b1; s2_funct = F_MFLO;
        #1;
        n_checks++;
        if (s2_sel !== 1'b1 || s2_hilo !== e_lo) begin
            n_errors++;
            $display("FAIL %s_lo: sel=%0b hilo=%h, expected 1 %h", nm, s2_sel, s2_hilo, e_lo);
        end
        @(negedge div_clk);
        s2_funct = F_MFHI;
        #1;
        n_checks++;
        if (s2_sel !== 1'b1 || s2_hilo !== e_hi) begin
            n_errors++;
            $display("FAIL %s_hi: sel=%0b hilo=%h, expected 1 %h", nm, s2_sel, s2_hilo, e_hi);
        end
        @(posedge div_clk); #1;
        s2_op_valid = 1'b0; s2_funct = 6'd0;
    endtask

    task automatic test_steps2();
        run_div2(32'd100, 32'd7, "s2_100_7");
        run_div2($urandom, 32'($urandom_range(1, 100000)), "s2_rand");
        run_div2(32'd9, 32'd0, "s2_zero");
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; op_valid = 1'b0; funct = 6'd0; dataA = '0; dataB = '0;
        s2_op_valid = 1'b0; s2_funct = 6'd0; s2_dataA = '0; s2_dataB = '0;
`ifdef DIV_ABORT_EN
        abort = 1'b0; s2_abort = 1'b0;
`endif
        test_reset();
        test_directed();
        test_stall_mf();
        test_back_to_back();
        test_other_funct();
        test_random();
        test_reset_mid_run();
`ifdef DIV_ABORT_EN
        test_abort();
`endif
        test_steps2();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected completion before 400000ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
